// File: rtl/baud_gen_pkg.sv
// Shared UART definitions: divisor width and the default-divisor calculation.
// The APB register block reuses calc_default_div for its divisor reset value.
package baud_gen_pkg;

  localparam int DIV_W = 32;

  // Truncating divide, clamped to [1, 2^32-1] so a divisor of zero can never be produced.
  function automatic logic [DIV_W-1:0] calc_default_div(
    input longint unsigned freq,
    input longint unsigned baud,
    input longint unsigned ovs
  );
    longint unsigned q;
    if ((baud * ovs) == 0) begin
      q = 1;
    end else begin
      q = freq / (baud * ovs);
    end
    if (q == 0) begin
      q = 1;
    end
    if (q > 64'h0000_0000_FFFF_FFFF) begin
      q = 64'h0000_0000_FFFF_FFFF;
    end
    return q[DIV_W-1:0];
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Oversample tick generator: one-cycle baud_clk every D clk cycles, D = div_in or the default when div_in is 0.
// A divisor change takes effect at the next edge and restarts the count; there is no backpressure.
module baud_gen
  import baud_gen_pkg::*;
#(
  parameter int unsigned clk_freq   = 100_000_000,
  parameter int unsigned oversample = 16,
  parameter int unsigned baud_rate  = 9600
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_in,
  output logic             baud_clk
);

  localparam logic [DIV_W-1:0] DEFAULT_DIV =
    calc_default_div(64'(clk_freq), 64'(baud_rate), 64'(oversample));

  logic [DIV_W-1:0] divisor;
  logic [DIV_W-1:0] counter;
  logic [DIV_W-1:0] w_new_div;
  logic             w_div_chg;

  assign w_new_div = (div_in == '0) ? DEFAULT_DIV : div_in;
  // Compare effective divisors so toggling div_in between 0 and DEFAULT_DIV does not restart.
  assign w_div_chg = (w_new_div != divisor);

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= DEFAULT_DIV;
    end else if (w_div_chg) begin
      divisor <= w_new_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_div_chg) begin
      counter  <= '0;
      baud_clk <= 1'b0;
    end else if (counter == (divisor - DIV_W'(1))) begin
      counter  <= '0;
      baud_clk <= 1'b1;
    end else begin
      counter  <= counter + DIV_W'(1);
      baud_clk <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Randomized and directed checks of baud_gen against an edge-count reference model.
module tb_baud_gen;

  localparam logic [31:0] DEF = 32'd651;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] div_in = 32'd0;
  logic        baud_clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: effective divisor and edges elapsed since the last restart.
  logic [31:0] m_div = DEF;
  longint      m_k = 0;
  logic        m_tick = 1'b0;

  baud_gen dut (
    .clk      (clk),
    .rst      (rst),
    .div_in   (div_in),
    .baud_clk (baud_clk)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_cnt();
    return 32'(m_k % longint'(m_div));
  endfunction

  // Advance one rising edge, update the model from the inputs seen at that edge, settle 1 ns.
  task automatic step();
    logic [31:0] nd;
    @(posedge clk);
    if (rst) begin
      m_div  = DEF;
      m_k    = 0;
      m_tick = 1'b0;
    end else begin
      nd = (div_in == 32'd0) ? DEF : div_in;
      if (nd != m_div) begin
        m_div  = nd;
        m_k    = 0;
        m_tick = 1'b0;
      end else begin
        m_k++;
        m_tick = ((m_k % longint'(m_div)) == 0);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div_in = 32'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      vecs++;
      if (baud_clk !== 1'b0) begin errs++; $display("FAIL reset_tick got %0b expected 0", baud_clk); end
      vecs++;
      if (dut.counter !== 32'd0) begin errs++; $display("FAIL reset_counter got %0d expected 0", dut.counter); end
    end
    vecs++;
    if (dut.divisor !== DEF) begin errs++; $display("FAIL reset_divisor got %0d expected %0d", dut.divisor, DEF); end
  endtask

  task automatic test_default();
    int    pulses = 0;
    time   last_t = 0;
    time   t;
    rst = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      step();
      vecs++;
      if (baud_clk !== m_tick) begin errs++; $display("FAIL default_tick edge %0d got %0b expected %0b", i, baud_clk, m_tick); end
      if (baud_clk === 1'b1) begin
        t = $time;
        if (pulses > 0) begin
          vecs++;
          if ((t - last_t) != 6510) begin errs++; $display("FAIL default_period got %0t expected 6510", t - last_t); end
        end
        last_t = t;
        pulses++;
      end
    end
    vecs++;
    if (pulses != 30) begin errs++; $display("FAIL default_pulse_count got %0d expected 30", pulses); end
    vecs++;
    if (dut.divisor !== DEF) begin errs++; $display("FAIL default_divisor got %0d expected %0d", dut.divisor, DEF); end
  endtask

  task automatic test_runtime_change();
    int  pulses = 0;
    int  first_at = -1;
    time last_t = 0;
    div_in = 32'd54;
    step();
    vecs++;
    if (dut.divisor !== 32'd54) begin errs++; $display("FAIL change_divisor got %0d expected 54", dut.divisor); end
    vecs++;
    if (dut.counter !== 32'd0) begin errs++; $display("FAIL change_counter got %0d expected 0", dut.counter); end
    for (int i = 1; i <= 540; i++) begin
      step();
      vecs++;
      if (baud_clk !== m_tick) begin errs++; $display("FAIL change_tick edge %0d got %0b expected %0b", i, baud_clk, m_tick); end
      if (baud_clk === 1'b1) begin
        if (first_at < 0) first_at = i;
        else begin
          vecs++;
          if (($time - last_t) != 540) begin errs++; $display("FAIL change_period got %0t expected 540", $time - last_t); end
        end
        last_t = $time;
        pulses++;
      end
    end
    vecs++;
    if (first_at != 54) begin errs++; $display("FAIL change_first_pulse got %0d expected 54", first_at); end
    vecs++;
    if (pulses != 10) begin errs++; $display("FAIL change_pulse_count got %0d expected 10", pulses); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int found = 0;
    div_in = 32'd0;
    for (int i = 0; i < 1400 && found == 0; i++) begin
      step();
      vecs++;
      if (baud_clk !== m_tick) begin errs++; $display("FAIL rstmid_tick got %0b expected %0b", baud_clk, m_tick); end
      if (dut.counter == 32'd300 && dut.divisor == DEF) found = 1;
    end
    vecs++;
    if (found == 0) begin errs++; $display("FAIL rstmid_reach_300 got timeout expected counter 300"); end
    rst = 1'b1;
    step();
    vecs++;
    if (dut.counter !== 32'd0) begin errs++; $display("FAIL rstmid_counter got %0d expected 0", dut.counter); end
    vecs++;
    if (baud_clk !== 1'b0) begin errs++; $display("FAIL rstmid_tick_low got %0b expected 0", baud_clk); end
    rst = 1'b0;
    found = 0;
    while (n < 700 && found == 0) begin
      step();
      n++;
      if (baud_clk === 1'b1) found = 1;
    end
    vecs++;
    if (found == 0 || n != 651) begin errs++; $display("FAIL rstmid_first_pulse got %0d expected 651", n); end
  endtask

  task automatic test_min_div();
    div_in = 32'd1;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      vecs++;
      if (baud_clk !== 1'b1) begin errs++; $display("FAIL div1_tick cycle %0d got %0b expected 1", i, baud_clk); end
    end
    div_in = 32'd2;
    step();
    vecs++;
    if (baud_clk !== 1'b0) begin errs++; $display("FAIL div2_change_tick got %0b expected 0", baud_clk); end
    for (int i = 1; i <= 8; i++) begin
      step();
      vecs++;
      if (baud_clk !== ((i % 2) == 0)) begin errs++; $display("FAIL div2_tick edge %0d got %0b expected %0b", i, baud_clk, (i % 2) == 0); end
    end
  endtask

  task automatic test_equal_div();
    int found = 0;
    int s = 0;
    div_in = 32'd0;
    for (int i = 0; i < 1400 && found == 0; i++) begin
      step();
      if (dut.counter == 32'd400 && dut.divisor == DEF) found = 1;
    end
    vecs++;
    if (found == 0) begin errs++; $display("FAIL equal_reach_400 got timeout expected counter 400"); end
    div_in = DEF;
    step();
    vecs++;
    if (dut.counter !== 32'd401) begin errs++; $display("FAIL equal_no_restart got %0d expected 401", dut.counter); end
    s = 1;
    found = 0;
    while (s < 400 && found == 0) begin
      step();
      s++;
      if (baud_clk === 1'b1) found = 1;
    end
    vecs++;
    if (found == 0 || s != 251) begin errs++; $display("FAIL equal_pulse_edge got %0d expected 251", s); end
  endtask

  task automatic test_shrink();
    int found = 0;
    int pulses = 0;
    for (int i = 0; i < 1400 && found == 0; i++) begin
      step();
      if (dut.counter == 32'd600) found = 1;
    end
    vecs++;
    if (found == 0) begin errs++; $display("FAIL shrink_reach_600 got timeout expected counter 600"); end
    div_in = 32'd10;
    step();
    vecs++;
    if (dut.counter !== 32'd0) begin errs++; $display("FAIL shrink_counter got %0d expected 0", dut.counter); end
    for (int i = 1; i <= 100; i++) begin
      step();
      vecs++;
      if (baud_clk !== ((i % 10) == 0)) begin errs++; $display("FAIL shrink_tick edge %0d got %0b expected %0b", i, baud_clk, (i % 10) == 0); end
      vecs++;
      if (dut.counter > 32'd9) begin errs++; $display("FAIL shrink_counter_max got %0d expected <=9", dut.counter); end
      if (baud_clk === 1'b1) pulses++;
    end
    vecs++;
    if (pulses != 10) begin errs++; $display("FAIL shrink_pulse_count got %0d expected 10", pulses); end
  endtask

  task automatic test_random();
    int hold;
    int sel;
    for (int seg = 0; seg < 40; seg++) begin
      sel = $urandom_range(0, 9);
      rst = (sel == 0);
      if (sel <= 2)      div_in = 32'd0;
      else if (sel == 3) div_in = DEF;
      else               div_in = $urandom_range(1, 40);
      hold = $urandom_range(1, 120);
      for (int i = 0; i < hold; i++) begin
        step();
        vecs++;
        if (baud_clk !== m_tick) begin errs++; $display("FAIL rand_tick seg %0d got %0b expected %0b", seg, baud_clk, m_tick); end
        vecs++;
        if (dut.counter !== m_cnt()) begin errs++; $display("FAIL rand_counter seg %0d got %0d expected %0d", seg, dut.counter, m_cnt()); end
        vecs++;
        if (dut.divisor !== m_div) begin errs++; $display("FAIL rand_divisor seg %0d got %0d expected %0d", seg, dut.divisor, m_div); end
        if (rst && i == 2) rst = 1'b0;
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_runtime_change();
    test_reset_mid();
    test_min_div();
    test_equal_div();
    test_shrink();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
